// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: queues settled vend transactions and fires product/nickel/dime
// actuators one at a time. Optional dispensed-coin counters under VEND_DISPENSE_COUNT_EN.
module vend_dispense_ctrl #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int CNT_W     = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_vend,
    input  logic [2:0]  req_change,
    input  logic        jam,
    output logic        product_motor,
    output logic        nickel_eject,
    output logic        dime_eject,
    output logic        busy,
    output logic        done,
    output logic        err_illegal,
    output logic [15:0] nickel_total,
    output logic [15:0] dime_total
);

    typedef enum logic [2:0] {IDLE, PROD, NICK, DIME, GAP, FIN} state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             prod_left, nick_left;
    logic [1:0]       dime_left;

    logic [3:0] q_mem [2];
    logic       q_wr, q_rd;
    logic [1:0] q_cnt;
    logic       push, pop;
    logic [3:0] head;
    logic       hd_nick, hd_ill;
    logic [1:0] hd_dime;
    state_t     pop_next, gap_next;

    function automatic state_t first_act(input logic p, input logic n, input logic [1:0] d);
        if (p)              return PROD;
        else if (n)         return NICK;
        else if (d != 2'd0) return DIME;
        else                return FIN;
    endfunction

    assign req_ready = reset_n && (q_cnt != 2'd2);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && !jam && (q_cnt != 2'd0);
    assign head      = q_mem[q_rd];

    always_comb begin
        hd_nick = 1'b0;
        hd_dime = 2'd0;
        hd_ill  = 1'b0;
        case (head[2:0])
            3'b000: ;
            3'b001: hd_nick = 1'b1;
            3'b010: hd_dime = 2'd1;
            3'b011: begin hd_nick = 1'b1; hd_dime = 2'd1; end
            3'b100: hd_dime = 2'd2;
            default: hd_ill = 1'b1;
        endcase
    end

    assign pop_next = first_act(head[3], hd_nick, hd_dime);
    assign gap_next = first_act(prod_left, nick_left, dime_left);

    // Two-entry FIFO, no bypass: an entry pushed on an edge is poppable only after it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_wr     <= 1'b0;
            q_rd     <= 1'b0;
            q_cnt    <= 2'd0;
            q_mem[0] <= 4'd0;
            q_mem[1] <= 4'd0;
        end else begin
            if (push) begin
                q_mem[q_wr] <= {req_vend, req_change};
                q_wr        <= ~q_wr;
            end
            if (pop) q_rd <= ~q_rd;
            q_cnt <= q_cnt + 2'(push) - 2'(pop);
        end
    end

    // Actuator flops are loaded with the state being entered, so jam (which holds
    // state/timer) only needs to let them fall to their default of 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            timer         <= '0;
            prod_left     <= 1'b0;
            nick_left     <= 1'b0;
            dime_left     <= 2'd0;
            product_motor <= 1'b0;
            nickel_eject  <= 1'b0;
            dime_eject    <= 1'b0;
            done          <= 1'b0;
            err_illegal   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            product_motor <= 1'b0;
            nickel_eject  <= 1'b0;
            dime_eject    <= 1'b0;
            done          <= 1'b0;
            err_illegal   <= 1'b0;
            busy          <= (state != IDLE) || (q_cnt != 2'd0) || push;
            case (state)
                IDLE: if (pop) begin
                    prod_left     <= head[3];
                    nick_left     <= hd_nick;
                    dime_left     <= hd_dime;
                    err_illegal   <= hd_ill;
                    timer         <= '0;
                    state         <= pop_next;
                    product_motor <= (pop_next == PROD);
                    nickel_eject  <= (pop_next == NICK);
                    dime_eject    <= (pop_next == DIME);
                end
                PROD, NICK, DIME: if (!jam) begin
                    if (timer == PULSE_LAST) begin
                        timer <= '0;
                        state <= GAP;
                        case (state)
                            PROD:    prod_left <= 1'b0;
                            NICK:    nick_left <= 1'b0;
                            default: dime_left <= dime_left - 2'd1;
                        endcase
                    end else begin
                        timer         <= timer + CNT_ONE;
                        product_motor <= (state == PROD);
                        nickel_eject  <= (state == NICK);
                        dime_eject    <= (state == DIME);
                    end
                end
                GAP: if (!jam) begin
                    if (timer == GAP_LAST) begin
                        timer         <= '0;
                        state         <= gap_next;
                        product_motor <= (gap_next == PROD);
                        nickel_eject  <= (gap_next == NICK);
                        dime_eject    <= (gap_next == DIME);
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                // FIN always completes so done stays a single-cycle pulse even under jam
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VEND_DISPENSE_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nickel_total <= 16'h0000;
            dime_total   <= 16'h0000;
        end else if (!jam && timer == PULSE_LAST) begin
            if (state == NICK && nickel_total != 16'hFFFF) nickel_total <= nickel_total + 16'd1;
            if (state == DIME && dime_total != 16'hFFFF)   dime_total   <= dime_total + 16'd1;
        end
    end
`else
    assign nickel_total = 16'h0000;
    assign dime_total   = 16'h0000;
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Randomised self-checking bench for vend_dispense_ctrl against a transaction-level
// model that expands each queued request into its expected per-cycle output trace.
module tb_vend_dispense_ctrl;
    localparam int P = 4;
    localparam int G = 2;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic        req_valid = 1'b0, req_vend = 1'b0, jam = 1'b0;
    logic [2:0]  req_change = 3'd0;
    logic        req_ready, product_motor, nickel_eject, dime_eject, busy, done, err_illegal;
    logic [15:0] nickel_total, dime_total;

    vend_dispense_ctrl #(.PULSE_CYC(P), .GAP_CYC(G), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_vend(req_vend), .req_change(req_change), .jam(jam),
        .product_motor(product_motor), .nickel_eject(nickel_eject), .dime_eject(dime_eject),
        .busy(busy), .done(done), .err_illegal(err_illegal),
        .nickel_total(nickel_total), .dime_total(dime_total)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    // Model: txq is the request FIFO; stream holds the expected per-cycle outputs.
    // Element bits: [5] controller idle, [4] prod, [3] nick, [2] dime, [1] done, [0] err
    logic [3:0] txq[$];
    logic [5:0] stream[$];
    logic       mbusy = 1'b0;
    logic       acc;

    wire [6:0] obs_vec = {product_motor, nickel_eject, dime_eject, done, err_illegal, busy, req_ready};

    function automatic logic [5:0] cur_elem();
        if (stream.size() != 0) return stream[0];
        return 6'b100000;
    endfunction

    function automatic logic [6:0] exp_vec();
        logic [5:0] e;
        e = cur_elem();
        return {e[4:0], mbusy, (txq.size() < 2)};
    endfunction

    task automatic add_action(input logic [5:0] b);
        repeat (P) stream.push_back(b);
        repeat (G) stream.push_back(6'b000000);
    endtask

    task automatic expand(input logic [3:0] t);
        int n = 0, d = 0, s;
        logic ill = 1'b0;
        logic [5:0] e;
        case (t[2:0])
            3'd0: ;
            3'd1: n = 1;
            3'd2: d = 1;
            3'd3: begin n = 1; d = 1; end
            3'd4: d = 2;
            default: ill = 1'b1;
        endcase
        s = stream.size();
        if (t[3]) add_action(6'b010000);
        repeat (n) add_action(6'b001000);
        repeat (d) add_action(6'b000100);
        stream.push_back(6'b000000);
        stream.push_back(6'b100010);
        e = stream[s];
        e[0] = ill;
        stream[s] = e;
    endtask

    // One clock: drive inputs at the negedge, advance the model, return at next negedge
    task automatic tick(input logic v, input logic vd, input logic [2:0] ch);
        logic [5:0] c;
        int cb;
        req_valid = v; req_vend = vd; req_change = ch;
        c = cur_elem();
        cb = txq.size();
        acc = v && (cb < 2);
        if (stream.size() != 0) void'(stream.pop_front());
        if (c[5] && cb > 0) expand(txq.pop_front());
        if (acc) txq.push_back({vd, ch});
        mbusy = !c[5] || (cb != 0) || acc;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({obs_vec, nickel_total, dime_total} !== 39'd0) begin
            errors++; $display("FAIL reset_hold: got %b want all zero", obs_vec);
        end
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (obs_vec !== 7'b0000001) begin
            errors++; $display("FAIL reset_release: got %b want 0000001", obs_vec);
        end
    endtask

    task automatic test_single(input logic vd, input logic [2:0] ch, input int wp, input int wn, input int wd);
        int ph = 0, nh = 0, dh = 0, dn = 0, en = 0, i;
        for (i = 0; i < 100; i++) begin
            tick(i == 0, vd, ch);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++; $display("FAIL single_%b cyc %0d: got %b want %b", ch, i, obs_vec, exp_vec());
            end
            ph += int'(product_motor); nh += int'(nickel_eject); dh += int'(dime_eject);
            dn += int'(done); en += int'(err_illegal);
            if (stream.size() == 0 && txq.size() == 0) break;
        end
        checks++;
        if ({ph, nh, dh, dn, en} !== {wp, wn, wd, 32'd1, (ch > 3'd4) ? 32'd1 : 32'd0}) begin
            errors++;
            $display("FAIL single_totals_%b: got p%0d n%0d d%0d done%0d err%0d want p%0d n%0d d%0d done1",
                     ch, ph, nh, dh, dn, en, wp, wn, wd);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] it [3] = '{4'b1001, 4'b0010, 4'b1100};
        logic [3:0] cur;
        int k = 0, dn = 0, nr = 0;
        for (int i = 0; i < 200; i++) begin
            cur = (k < 3) ? it[k] : 4'd0;
            tick(k < 3, cur[3], cur[2:0]);
            if (acc) k++;
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++; $display("FAIL b2b cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
            dn += int'(done);
            nr += int'(!req_ready);
            if (k == 3 && stream.size() == 0 && txq.size() == 0) break;
        end
        checks++;
        if (dn != 3 || nr == 0 || k != 3) begin
            errors++; $display("FAIL b2b_summary: got done=%0d notready=%0d accepted=%0d want 3/>0/3", dn, nr, k);
        end
    endtask

    task automatic test_random;
        int i;
        for (i = 0; i < 600; i++) begin
            if (i < 400) tick($urandom_range(0, 2) == 0, 1'($urandom), 3'($urandom_range(0, 7)));
            else         tick(1'b0, 1'b0, 3'd0);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
            if (i >= 400 && stream.size() == 0 && txq.size() == 0) break;
        end
        checks++;
        if (i >= 600) begin
            errors++; $display("FAIL random_drain: got still busy want drained");
        end
    endtask

    task automatic test_jam;
        logic [13:0] tr = '0;
        int w, other = 0;
        req_valid = 1'b1; req_vend = 1'b0; req_change = 3'b001;
        @(posedge clock); @(negedge clock); req_valid = 1'b0;
        for (w = 0; w < 10 && !nickel_eject; w++) begin
            @(posedge clock); @(negedge clock);
        end
        tr[0] = nickel_eject;
        @(posedge clock); @(negedge clock);
        tr[1] = nickel_eject;
        jam = 1'b1;
        for (int i = 2; i < 14; i++) begin
            @(posedge clock); @(negedge clock);
            tr[i] = nickel_eject;
            other += int'(product_motor) + int'(dime_eject);
            if (i == 6) jam = 1'b0;
        end
        checks++;
        if (tr !== 14'b00000110000011 || other != 0) begin
            errors++; $display("FAIL jam_trace: got %b other=%0d want 00000110000011 other=0", tr, other);
        end
        for (w = 0; w < 20 && busy; w++) begin
            @(posedge clock); @(negedge clock);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL jam_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_pulse;
        int bad = 0;
        req_valid = 1'b1; req_vend = 1'b0; req_change = 3'b010;
        @(posedge clock); @(negedge clock); req_vend = 1'b1; req_change = 3'b000;
        @(posedge clock); @(negedge clock); req_vend = 1'b0; req_change = 3'b001;
        @(posedge clock); @(negedge clock); req_valid = 1'b0;
        checks++;
        if ({dime_eject, req_ready} !== 2'b10) begin
            errors++; $display("FAIL pre_reset: got dime=%b ready=%b want 1 0", dime_eject, req_ready);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({dime_eject, busy, req_ready, nickel_total, dime_total} !== 35'd0) begin
            errors++; $display("FAIL async_reset: got dime=%b busy=%b ready=%b nt=%0d dt=%0d want 0",
                               dime_eject, busy, req_ready, nickel_total, dime_total);
        end
        @(negedge clock); reset_n = 1'b1;
        repeat (30) begin
            @(posedge clock); @(negedge clock);
            if (obs_vec !== 7'b0000001) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL queue_flushed: got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset;
        test_single(1'b1, 3'b011, 4, 4, 4);
        test_single(1'b0, 3'b100, 0, 0, 8);
        test_back_to_back;
        test_single(1'b0, 3'b110, 0, 0, 0);
        test_random;
        test_jam;
        test_reset_mid_pulse;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
